// File: rtl/decode_issue_queue.sv
// Purpose : in-order decode->execute issue queue (DEPTH-entry FIFO) with a
//           per-register latency scoreboard that interlocks RAW/WAW hazards
//           against long-latency producers (load, divide, CSR write).
// Latency : 1 cycle minimum from push to head (no same-cycle bypass).
// Backpressure: in_ready drops when full or during clear; out_valid is held
//           low while the head entry is blocked by the scoreboard or during clear.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   clear                pipeline flush, empties the queue at the next edge
//   in_*                 enqueue handshake and decoded instruction fields
//   out_*                head entry handshake and fields (all 0 when empty)
//   wb_valid, wb_waddr   early completion of a long-latency producer
//   hazard               head present but blocked by the scoreboard
//   count                current occupancy, 0..DEPTH
module decode_issue_queue #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4,
   parameter int NREG  = 32,
   parameter int LAT_W = 3,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1,
   localparam int RW   = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   // enqueue side
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_pc,
   input  logic [31:0]      in_instr,
   input  logic [RW-1:0]    in_waddr,
   input  logic [RW-1:0]    in_raddr1,
   input  logic [RW-1:0]    in_raddr2,
   input  logic             in_wren,
   input  logic             in_rden1,
   input  logic             in_rden2,
   input  logic [LAT_W-1:0] in_lat,
   // issue side
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_pc,
   output logic [31:0]      out_instr,
   output logic [RW-1:0]    out_waddr,
   output logic [RW-1:0]    out_raddr1,
   output logic [RW-1:0]    out_raddr2,
   output logic             out_wren,
   output logic             out_rden1,
   output logic             out_rden2,
   output logic [LAT_W-1:0] out_lat,
   // writeback / status
   input  logic             wb_valid,
   input  logic [RW-1:0]    wb_waddr,
   output logic             hazard,
   output logic [CW-1:0]    count
);

   // ------------------------------------------------------------------
   // Queue state
   // ------------------------------------------------------------------
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;

   logic [XLEN-1:0]  r_pc     [DEPTH];
   logic [31:0]      r_instr  [DEPTH];
   logic [RW-1:0]    r_waddr  [DEPTH];
   logic [RW-1:0]    r_raddr1 [DEPTH];
   logic [RW-1:0]    r_raddr2 [DEPTH];
   logic             r_wren   [DEPTH];
   logic             r_rden1  [DEPTH];
   logic             r_rden2  [DEPTH];
   logic [LAT_W-1:0] r_lat    [DEPTH];

   // Per-register cycles remaining until the result is forwardable.
   // Entry 0 exists only to keep indexing simple; it is held at zero.
   logic [LAT_W-1:0] r_cnt    [NREG];

   // ------------------------------------------------------------------
   // Head entry and handshakes
   // ------------------------------------------------------------------
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic [XLEN-1:0]  w_h_pc;
   logic [31:0]      w_h_instr;
   logic [RW-1:0]    w_h_waddr;
   logic [RW-1:0]    w_h_raddr1;
   logic [RW-1:0]    w_h_raddr2;
   logic             w_h_wren;
   logic             w_h_rden1;
   logic             w_h_rden2;
   logic [LAT_W-1:0] w_h_lat;
   logic             w_haz_r1;
   logic             w_haz_r2;
   logic             w_haz_w;

   assign w_empty    = (r_count == '0);

   assign w_h_pc     = r_pc    [r_rd_ptr];
   assign w_h_instr  = r_instr [r_rd_ptr];
   assign w_h_waddr  = r_waddr [r_rd_ptr];
   assign w_h_raddr1 = r_raddr1[r_rd_ptr];
   assign w_h_raddr2 = r_raddr2[r_rd_ptr];
   assign w_h_wren   = r_wren  [r_rd_ptr];
   assign w_h_rden1  = r_rden1 [r_rd_ptr];
   assign w_h_rden2  = r_rden2 [r_rd_ptr];
   assign w_h_lat    = r_lat   [r_rd_ptr];

   // Ready depends only on registered occupancy: a push while full is
   // refused even if the head pops in the same cycle.
   assign in_ready   = (r_count != CW'(DEPTH)) & ~clear;

   // RAW on either source, or WAW on the destination, against a producer
   // whose result is still in flight. x0 is never interlocked.
   assign w_haz_r1   = w_h_rden1 & (w_h_raddr1 != '0) & (r_cnt[w_h_raddr1] != '0);
   assign w_haz_r2   = w_h_rden2 & (w_h_raddr2 != '0) & (r_cnt[w_h_raddr2] != '0);
   assign w_haz_w    = w_h_wren  & (w_h_waddr  != '0) & (r_cnt[w_h_waddr]  != '0);

   assign hazard     = ~w_empty & (w_haz_r1 | w_haz_r2 | w_haz_w);
   assign out_valid  = ~w_empty & ~hazard & ~clear;

   assign w_push     = in_valid & in_ready;
   assign w_pop      = out_valid & out_ready;

   // Head fields are forced to zero while the queue is empty so that stale
   // storage never leaks onto the execute bus.
   assign out_pc     = w_empty ? '0 : w_h_pc;
   assign out_instr  = w_empty ? '0 : w_h_instr;
   assign out_waddr  = w_empty ? '0 : w_h_waddr;
   assign out_raddr1 = w_empty ? '0 : w_h_raddr1;
   assign out_raddr2 = w_empty ? '0 : w_h_raddr2;
   assign out_wren   = w_empty ? 1'b0 : w_h_wren;
   assign out_rden1  = w_empty ? 1'b0 : w_h_rden1;
   assign out_rden2  = w_empty ? 1'b0 : w_h_rden2;
   assign out_lat    = w_empty ? '0 : w_h_lat;

   assign count      = r_count;

   // ------------------------------------------------------------------
   // Pointers and occupancy
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         // DEPTH is a power of two, so pointer overflow is the modulo wrap.
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Entry storage: contents are don't-care until pushed, so no reset.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc    [r_wr_ptr] <= in_pc;
         r_instr [r_wr_ptr] <= in_instr;
         r_waddr [r_wr_ptr] <= in_waddr;
         r_raddr1[r_wr_ptr] <= in_raddr1;
         r_raddr2[r_wr_ptr] <= in_raddr2;
         r_wren  [r_wr_ptr] <= in_wren;
         r_rden1 [r_wr_ptr] <= in_rden1;
         r_rden2 [r_wr_ptr] <= in_rden2;
         r_lat   [r_wr_ptr] <= in_lat;
      end
   end

   // ------------------------------------------------------------------
   // Scoreboard. Not touched by clear: producers that already issued
   // still complete and must keep interlocking younger instructions.
   // Priority: issue load > writeback clear > decrement, so an issue and a
   // writeback to the same register in one cycle keep the issue latency.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++) begin
            r_cnt[r] <= '0;
         end
      end else begin
         r_cnt[0] <= '0;
         for (int r = 1; r < NREG; r++) begin
            if (w_pop & w_h_wren & (w_h_waddr == RW'(r)) & (w_h_lat != '0)) begin
               r_cnt[r] <= w_h_lat;
            end else if (wb_valid & (wb_waddr == RW'(r))) begin
               r_cnt[r] <= '0;
            end else if (r_cnt[r] != '0) begin
               r_cnt[r] <= r_cnt[r] - LAT_W'(1);
            end
         end
      end
   end

endmodule

// File: doc/decode_issue_queue.md
Name: decode_issue_queue

Overview:
Parametrised successor to the single-register decode stage. It sits between decode and execute and buffers up to DEPTH decoded instruction bundles in a FIFO. Issue is in order, one per cycle, under a valid/ready handshake. A per-register latency scoreboard stalls issue of the head entry on RAW or WAW hazards against long-latency producers still in flight (loads, division, CSR writes).

Parameters:
XLEN, 32, width of pc field
DEPTH, 4, queue entries; power of two, >=2
NREG, 32, architectural registers; register 0 is hard-wired zero and never tracked
LAT_W, 3, width of per-register pending-latency counter and of in_lat

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-high
clear  in  1  pipeline flush (jump/exception/mret)
in_valid  in  1  enqueue request
in_ready  out  1  queue can accept
in_pc  in  XLEN  instruction pc
in_instr  in  32  raw instruction
in_waddr  in  $clog2(NREG)  destination register
in_raddr1  in  $clog2(NREG)  source register 1
in_raddr2  in  $clog2(NREG)  source register 2
in_wren  in  1  destination written
in_rden1  in  1  source 1 read
in_rden2  in  1  source 2 read
in_lat  in  LAT_W  cycles before result is forwardable; 0 = no interlock
out_valid  out  1  head entry issuable
out_ready  in  1  execute accepts
out_pc, out_instr, out_waddr, out_raddr1, out_raddr2, out_wren, out_rden1, out_rden2, out_lat  out  as inputs  head entry fields
wb_valid  in  1  early completion of a long-latency producer
wb_waddr  in  $clog2(NREG)  register completed
hazard  out  1  head present but blocked by scoreboard
count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset (async, rst=1): rd/wr pointers, count and all scoreboard counters are 0. Outputs: out_valid=0, hazard=0, in_ready=1, count=0, all out_* fields=0.
- in_ready = (count != DEPTH) & !clear. The ready signal is registered-state based, so a push while full is refused even if a pop happens in the same cycle.
- Push occurs when in_valid & in_ready. The entry is written at the edge and becomes visible at the head no earlier than the next cycle; there is no same-cycle bypass, so minimum latency is 1 cycle.
- Pop occurs when out_valid & out_ready. Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- When count=0, out_* fields read 0.
- Scoreboard: cnt[r] is LAT_W bits, one per register 1..NREG-1.
- hazard = (count != 0) & ((rden1 & raddr1 != 0 & cnt[raddr1] != 0) | (rden2 & raddr2 != 0 & cnt[raddr2] != 0) | (wren & waddr != 0 & cnt[waddr] != 0)), all fields taken from the head entry.
- out_valid = (count != 0) & !hazard & !clear.
- Per-cycle counter update, in priority order, highest first:
  1. A pop with out_wren & out_waddr != 0 & out_lat != 0 sets cnt[out_waddr] = out_lat.
  2. wb_valid clears cnt[wb_waddr] to 0.
  3. Otherwise each nonzero counter decrements by 1.
  An issue and a writeback to the same register in the same cycle therefore leave the issue value. wb_valid with wb_waddr=0 has no effect.
- Clear: the queue empties at the next edge (pointers and count go to 0). In the clear cycle there is no push (in_ready=0) and no pop (out_valid=0). The scoreboard is not cleared, because already-issued producers still complete.
- Reset mid-operation: all state returns immediately to reset values regardless of clk.
- Count never exceeds DEPTH and never underflows. A pop while empty is impossible because out_valid=0.

Test Plan:
- Fill/drain, DEPTH=4: push 4 entries (pc 0x100..0x10C) with out_ready=0 -> count=4, in_ready=0. Then out_ready=1 -> pcs issue in order, one per cycle, and count reaches 0.
- Load-use: issue a load (waddr=5, lat=2), then an entry with rden1, raddr1=5 -> hazard=1 and out_valid=0 for 2 cycles, then it issues on the 3rd.
- Early release: issue a divide (waddr=7, lat=7), a dependent entry waits, pulse wb_valid with wb_waddr=7 -> dependent entry is valid the next cycle.
- Same-cycle conflict: wb_valid to x3 in the same cycle that an issue sets cnt[3]=4 -> cnt[3]=4 and a subsequent reader of x3 stalls 4 cycles.
- Register 0: a producer with waddr=0 and lat=5 is followed by a reader of x0 -> no hazard; the reader issues the next cycle.
- Flush and reset: 3 entries queued plus cnt[9]=3, assert clear -> count=0 next cycle and cnt[9] keeps decrementing. Then assert rst asynchronously mid-push -> every output returns to its reset value without waiting for a clock edge.
